// File: rtl/btn_repeat_pulser_if.sv
// Button pin and conditioned outputs of btn_repeat_pulser.
// btn: raw pin, pulse: 1-clk press/repeat strobe, held: debounced pressed level.
interface btn_repeat_pulser_if;
    logic btn;
    logic pulse;
    logic held;

    modport master (
        output btn,
        input  pulse,
        input  held
    );

    modport slave (
        input  btn,
        output pulse,
        output held
    );
endinterface

// File: rtl/btn_repeat_pulser.sv
// Push-button conditioner: sync, debounce, press pulse and optional auto-repeat.
// Ports: clk, rst_n (sync active-low), bus.slave {btn in, pulse out, held out}.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_repeat_pulser #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    btn_repeat_pulser_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Pin is registered once after polarity correction, then passes
    // a two-flop synchroniser; btn_s is valid two clocks after sampling.
    logic pin_q;
    logic sync_q;
    logic btn_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pin_q  <= 1'b0;
            sync_q <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            pin_q  <= bus.btn ^ ACTIVE_LOW;
            sync_q <= pin_q;
            btn_s  <= sync_q;
        end
    end

    logic            held_q;
    logic [DB_W-1:0] db_cnt;

    // A reversal makes btn_s match held again, which clears the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == held_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            held_q <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    logic pulse_q;
    logic pulse_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DLY,
        REPEAT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [RP_W-1:0] rp_cnt_q;
    logic [RP_W-1:0] rp_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rp_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rp_cnt_q <= rp_cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Release is checked before the terminal count so it wins.
    always_comb begin
        state_d  = state_q;
        rp_cnt_d = rp_cnt_q;
        pulse_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (held_q) begin
                    pulse_d  = 1'b1;
                    rp_cnt_d = '0;
                    state_d  = WAIT_DLY;
                end
            end
            WAIT_DLY: begin
                if (!held_q) begin
                    rp_cnt_d = '0;
                    state_d  = IDLE;
                end else if (rp_cnt_q == RP_W'(REPEAT_DELAY - 1)) begin
                    pulse_d  = 1'b1;
                    rp_cnt_d = '0;
                    state_d  = REPEAT;
                end else begin
                    rp_cnt_d = rp_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!held_q) begin
                    rp_cnt_d = '0;
                    state_d  = IDLE;
                end else if (rp_cnt_q == RP_W'(REPEAT_PERIOD - 1)) begin
                    pulse_d  = 1'b1;
                    rp_cnt_d = '0;
                end else begin
                    rp_cnt_d = rp_cnt_q + 1'b1;
                end
            end
            default: begin
                rp_cnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end
`else
    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (held_q) begin
                    pulse_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!held_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
`endif

    assign bus.pulse = pulse_q;
    assign bus.held  = held_q;

endmodule

// File: tb/tb_btn_repeat_pulser.sv
// Directed bench for btn_repeat_pulser (D=4, delay=10, period=5, active-high).
// Cycle k means the k-th rising edge; outputs are checked 1 time unit after it.
module tb_btn_repeat_pulser;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    btn_repeat_pulser_if bus ();

    btn_repeat_pulser #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic b, input logic r);
        bus.btn = b;
        rst_n   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k,
                       input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b",
                   tag, k, obs, exp);
        end
    endtask

    task automatic clean_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("rst_pulse", i, bus.pulse, 1'b0);
            chk("rst_held", i, bus.held, 1'b0);
        end
    endtask

    function automatic logic long_pulse(input int k);
`ifdef BTN_AUTOREPEAT_EN
        return k inside {7, 17, 22, 27, 32, 37, 42};
`else
        return k == 7;
`endif
    endfunction

    function automatic logic mid_pulse(input int k);
`ifdef BTN_AUTOREPEAT_EN
        return k inside {7, 17};
`else
        return k == 7;
`endif
    endfunction

    initial begin
        vectors = 0;
        errors  = 0;
        bus.btn = 1'b0;
        rst_n   = 1'b0;

        // Button pressed through reset, then a fresh press.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("prerst_pulse", i, bus.pulse, 1'b0);
            chk("prerst_held", i, bus.held, 1'b0);
        end
        for (int k = 0; k <= 12; k++) begin
            step(1'b1, 1'b1);
            chk("rstpress_held", k, bus.held, logic'(k >= 6));
            chk("rstpress_pulse", k, bus.pulse, logic'(k == 7));
        end

        // Bounce: 2 high / 2 low for 20 cycles, then low.
        clean_reset();
        for (int k = 0; k < 40; k++) begin
            step(logic'(k < 20 && ((k / 2) % 2 == 0)), 1'b1);
            chk("bounce_held", k, bus.held, 1'b0);
            chk("bounce_pulse", k, bus.pulse, 1'b0);
        end

        // Single short press: pin high for cycles 0-7.
        clean_reset();
        for (int k = 0; k <= 25; k++) begin
            step(logic'(k <= 7), 1'b1);
            chk("single_held", k, bus.held, logic'(k >= 6 && k <= 13));
            chk("single_pulse", k, bus.pulse, logic'(k == 7));
        end

        // Long hold: pin high for cycles 0-39.
        clean_reset();
        for (int k = 0; k <= 55; k++) begin
            step(logic'(k <= 39), 1'b1);
            chk("long_held", k, bus.held, logic'(k >= 6 && k <= 45));
            chk("long_pulse", k, bus.pulse, long_pulse(k));
        end

        // Reset in the middle of a hold.
        clean_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1);
            chk("mid_held", k, bus.held, logic'(k >= 6));
            chk("mid_pulse", k, bus.pulse, mid_pulse(k));
        end
        step(1'b1, 1'b0);
        chk("midrst_held", 20, bus.held, 1'b0);
        chk("midrst_pulse", 20, bus.pulse, 1'b0);
        for (int j = 0; j <= 12; j++) begin
            step(1'b1, 1'b1);
            chk("after_held", 21 + j, bus.held, logic'(j >= 6));
            chk("after_pulse", 21 + j, bus.pulse, logic'(j == 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/btn_repeat_pulser.md
Name: btn_repeat_pulser

Overview:
- Upstream conditioning stage for the saturating counter. It turns one raw mechanical push-button into clean single-cycle increment/decrement pulses.
- Synchronises the async pin, debounces it, and emits one pulse per press. While the button stays held, it auto-repeats pulses so the counter can be driven to saturation without repeated tapping.
- Two instances feed the SATURATION pulse inputs (increase/decrease) directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive clocks the synchronised level must hold before it is accepted (>=1).
- REPEAT_DELAY, 25000000, clocks from the press pulse to the first auto-repeat pulse (>=1).
- REPEAT_PERIOD, 5000000, clocks between subsequent auto-repeat pulses (>=1).
- ACTIVE_LOW, 1, 1 = button pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- btn  input  1  raw asynchronous button pin.
- pulse  output  1  one-clock-wide press/repeat pulse.
- held  output  1  debounced pressed level (1 = pressed).

Behaviour:
- Reset is synchronous and active-low, sampled on clk rising edge. While rst_n=0:
  - pulse=0, held=0.
  - Sync flops are loaded with the "released" level.
  - Debounce and repeat counters are set to 0; FSM goes to IDLE.
- Polarity: btn_p = btn XOR ACTIVE_LOW (1 = pressed), applied before the synchroniser.
- Synchroniser: 2 flops, giving btn_s 2 clocks after sampling.
- Debounce:
  - db_cnt clears whenever btn_s == held.
  - While btn_s != held, db_cnt increments each clock.
  - When db_cnt == DEBOUNCE_CYCLES-1 and btn_s still differs, held <= btn_s and db_cnt <= 0.
  - Any mismatch reversal restarts the count.
- Counter widths are $clog2(max+1). No counter wraps: each is cleared on reaching its terminal value.
- FSM states: IDLE, WAIT_DLY, REPEAT. The pulse register is set for exactly one clock on each event listed below and is 0 otherwise.
  - IDLE:
    - held rising -> pulse=1 next cycle; rp_cnt<=0; go to WAIT_DLY.
  - WAIT_DLY:
    - held=0 -> IDLE, no pulse.
    - Otherwise rp_cnt increments.
    - At rp_cnt == REPEAT_DELAY-1 -> pulse, rp_cnt<=0, go to REPEAT.
  - REPEAT:
    - held=0 -> IDLE, no pulse.
    - Otherwise at rp_cnt == REPEAT_PERIOD-1 -> pulse, rp_cnt<=0.
- Press latency: first rising edge sampling a pressed pin at edge 0 -> held=1 after edge DEBOUNCE_CYCLES+2 -> pulse=1 after edge DEBOUNCE_CYCLES+3 (one clock wide).
- Spacing: first repeat pulse is REPEAT_DELAY clocks after the press pulse; later pulses are REPEAT_PERIOD clocks apart.
- Release priority: a held fall in the same cycle as a terminal count suppresses that pulse.
- Release latency: held falls DEBOUNCE_CYCLES+2 clocks after the pin releases. Repeat pulses falling inside that window are still emitted.
- Button pressed during reset: after rst_n=1, it is treated as a fresh press and produces a press pulse with the normal latency.
- Reset mid-hold: state is lost immediately; no pulse during reset.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: full behaviour above (WAIT_DLY/REPEAT active).
- Undefined:
  - After the press pulse the FSM stays in a HOLD state until held=0, emitting no further pulses.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored, and the rp_cnt counter is not synthesised.
  - Ports are unchanged.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, ACTIVE_LOW=0; cycle 0 = first edge sampling btn=1; macro defined unless stated):
- Reset: rst_n=0 for 3 cycles with btn=1 -> pulse=0, held=0 throughout. First edge with rst_n=1 counts as cycle 0 -> held=1 at 6, pulse at cycle 7 only.
- Bounce: btn toggles every 2 cycles for 20 cycles, then stays 0 -> pulse never 1, held stays 0.
- Single press: btn=1 for cycles 0-7, then 0 -> held 1 from 6 to 13, single pulse at 7, no others.
- Long hold: btn=1 for cycles 0-39, release at 40 -> pulses exactly at 7, 17, 22, 27, 32, 37, 42. held falls at 46; no pulse at or after 47.
- Macro undefined, same long hold -> exactly one pulse at 7; held timing unchanged.
- Reset mid-hold: btn=1 from 0, rst_n=0 at cycle 20 for 1 cycle -> pulse=0 and held=0 after edge 20. Counting cycle 21 as new cycle 0, held=1 at 27 and press pulse at 28; no pulse between 20 and 27.
